// File: rtl/store_buffer.sv
// FIFO store buffer between EX/MEM and data memory. Loads own the memory port first; queued
// stores drain one per cycle otherwise. Stalls on full, load-after-store word hit, and fence.
module store_buffer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PTR_W   = 2,
  parameter int unsigned WORD_AW = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_st_valid,
  input  logic             i_ld_valid,
  input  logic             i_fence,
  input  logic [31:0]      i_addr,
  input  logic [2:0]       i_rw_type,
  input  logic [31:0]      i_wdata,
  output logic             o_stall,
  output logic             o_mem_w_en,
  output logic             o_mem_r_en,
  output logic [31:0]      o_mem_addr,
  output logic [2:0]       o_mem_rw_type,
  output logic [31:0]      o_mem_din,
  output logic             o_sb_empty,
  output logic             o_sb_full,
  output logic [PTR_W:0]   o_sb_count
);

  typedef enum logic {StRun, StFence} state_e;

  state_e             r_state;
  logic [31:0]        r_addr [DEPTH];
  logic [1:0]         r_type [DEPTH];
  logic [31:0]        r_data [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;

  logic               w_empty;
  logic               w_full;
  logic               w_hit;
  logic               w_load_go;
  logic               w_pop;
  logic               w_push;
  logic               w_stall;
  logic [PTR_W:0]     w_count_nxt;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (PTR_W+1)'(DEPTH));

  // An entry is live when its distance from the head is below the count.
  always_comb begin : hit_scan
    logic [PTR_W-1:0] off;
    off   = '0;
    w_hit = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      off = PTR_W'(i) - r_rd_ptr;
      if (({1'b0, off} < r_count) &&
          (r_addr[i][WORD_AW+1:2] == i_addr[WORD_AW+1:2])) begin
        w_hit = 1'b1;
      end
    end
  end

  assign w_stall     = (i_st_valid & w_full) | (i_ld_valid & w_hit) |
                       (r_state == StFence) | (i_fence & ~w_empty);
  assign w_load_go   = i_rst_n & i_ld_valid & ~w_hit & (r_state == StRun);
  assign w_pop       = i_rst_n & ~w_load_go & ~w_empty;
  assign w_push      = i_rst_n & i_st_valid & ~w_stall;
  assign w_count_nxt = r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= StRun;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      // Leaving fence is tied to the buffer running dry, including a fence that empties it at once.
      if (w_count_nxt == '0) begin
        r_state <= StRun;
      end else if ((r_state == StRun) && i_fence && !w_empty) begin
        r_state <= StFence;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= i_addr;
      r_type[r_wr_ptr] <= i_rw_type[1:0];
      r_data[r_wr_ptr] <= i_wdata;
    end
  end

  always_comb begin
    o_mem_w_en    = 1'b0;
    o_mem_r_en    = 1'b0;
    o_mem_addr    = '0;
    o_mem_rw_type = '0;
    o_mem_din     = '0;
    if (w_load_go) begin
      o_mem_r_en    = 1'b1;
      o_mem_addr    = i_addr;
      o_mem_rw_type = i_rw_type;
    end else if (w_pop) begin
      o_mem_w_en    = 1'b1;
      o_mem_addr    = r_addr[r_rd_ptr];
      o_mem_rw_type = {1'b0, r_type[r_rd_ptr]};
      o_mem_din     = r_data[r_rd_ptr];
    end
  end

  assign o_stall    = i_rst_n & w_stall;
  assign o_sb_empty = ~i_rst_n | w_empty;
  assign o_sb_full  = i_rst_n & w_full;
  assign o_sb_count = i_rst_n ? r_count : '0;

endmodule
